// File: rtl/vid_line_prefetch.sv
// vid_line_prefetch
//   Video-side client of the SDRAM-backed static RAM controller. Once per
//   scanline it walks LINE_WORDS consecutive 16-bit words starting at
//   line_base and drops them into a double-buffered line store. The pixel
//   pipeline reads the other half of the store, so it never stalls on SDRAM.
//   The controller has no valid strobe: a read starts whenever the address
//   changes. Each address is therefore held for a fixed WAIT_CYCLES clocks,
//   and vid_data is sampled at the last of those clocks.
//
// Ports
//   clk         system clock, shared with the RAM controller
//   init_n      synchronous active-low reset
//   line_start  one-clock pulse that starts a fetch of a new line
//   line_base   byte address of the first word, sampled on line_start
//   vid_addr    address presented to the controller's video port
//   vid_data    word returned by the controller for vid_addr
//   rd_addr     pixel-side word index into the display bank
//   rd_data     display-bank word at rd_addr, one clock of latency
//   busy        high while a fetch is in progress
//   done        one-clock pulse when the last word of a line is stored
//   overrun     sticky flag: a line_start arrived while a fetch was running
module vid_line_prefetch #(
  parameter int LINE_WORDS  = 128,
  parameter int WAIT_CYCLES = 20
) (
  input  logic                          clk,
  input  logic                          init_n,
  input  logic                          line_start,
  input  logic [24:0]                   line_base,
  output logic [24:0]                   vid_addr,
  input  logic [15:0]                   vid_data,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_addr,
  output logic [15:0]                   rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam logic [5:0]    CNT_RELOAD = 6'(WAIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(LINE_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic          r_wrBank;
  logic [IW-1:0] r_idx;
  logic [5:0]    r_cnt;
  logic [24:0]   r_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;
  logic [15:0]   r_rdData;

  // Bank select is the top address bit, so the two banks share one RAM.
  logic [15:0]   r_mem [0:2*LINE_WORDS-1];

  state_t        w_state;
  logic          w_wrBank;
  logic [IW-1:0] w_idx;
  logic [5:0]    w_cnt;
  logic [24:0]   w_addr;
  logic          w_busy;
  logic          w_done;
  logic          w_overrun;
  logic          w_store;
  logic          w_last;

  // The hold interval ends when the counter reaches zero; that edge stores.
  assign w_store = (r_state == S_WAIT) && (r_cnt == 6'd0);
  assign w_last  = w_store && (r_idx == LAST_IDX);

  // Next-state logic. The WAIT handling runs first and a line_start then
  // overrides it, so a restart wins over both the normal step and the final
  // store, while done from a final store on the same edge is kept. An
  // abandoned fetch is only flagged as an overrun if it was not just
  // finishing on this very edge.
  always_comb begin
    w_state   = r_state;
    w_wrBank  = r_wrBank;
    w_idx     = r_idx;
    w_cnt     = r_cnt;
    w_addr    = r_addr;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_overrun = r_overrun;

    case (r_state)
      S_WAIT: begin
        if (r_cnt != 6'd0) begin
          w_cnt = r_cnt - 6'd1;
        end else if (w_last) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_idx  = r_idx + IW'(1);
          w_addr = r_addr + 25'd2;
          w_cnt  = CNT_RELOAD;
        end
      end
      default: ;
    endcase

    if (line_start) begin
      if ((r_state == S_WAIT) && !w_last) begin
        w_overrun = 1'b1;
      end
      w_wrBank = ~r_wrBank;
      w_addr   = line_base;
      w_idx    = '0;
      w_cnt    = CNT_RELOAD;
      w_busy   = 1'b1;
      w_state  = S_WAIT;
    end
  end

  // Control registers with synchronous reset, which beats any line_start.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state   <= S_IDLE;
      r_wrBank  <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= 6'd0;
      r_addr    <= 25'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_wrBank  <= w_wrBank;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_addr    <= w_addr;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_overrun <= w_overrun;
    end
  end

  // Fetch-side write port. The store has no reset so it maps onto block RAM;
  // a write is only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (init_n && w_store) begin
      r_mem[{r_wrBank, r_idx}] <= vid_data;
    end
  end

  // Pixel-side read port. It always reads the bank not being written, so the
  // two ports never touch the same word on the same edge.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_rdData <= 16'd0;
    end else begin
      r_rdData <= r_mem[{~r_wrBank, rd_addr}];
    end
  end

  assign vid_addr = r_addr;
  assign rd_data  = r_rdData;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_vid_line_prefetch.sv
// tb_vid_line_prefetch
//   Bench for vid_line_prefetch with LINE_WORDS=4, WAIT_CYCLES=20. The RAM
//   controller is modelled as a delay line: vid_data follows vid_addr[16:1]
//   only after WAIT_CYCLES-1 clocks, so sampling one clock early returns the
//   previous word. A reference model based on elapsed time since line_start
//   predicts every output each cycle; table-driven and hand-written sequences
//   cover the specific corner cases.
module tb_vid_line_prefetch;

  localparam int LW = 4;
  localparam int W  = 20;

  logic        clk = 1'b0;
  logic        init_n;
  logic        line_start;
  logic [24:0] line_base;
  logic [24:0] vid_addr;
  logic [15:0] vid_data;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        overrun;

  always #5 clk = ~clk;

  vid_line_prefetch #(
    .LINE_WORDS (LW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .line_start(line_start),
    .line_base (line_base),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  // Controller model: the returned word lags the address by W-1 clocks.
  logic [24:0] dly [0:W-2];
  always @(posedge clk) begin
    dly[0] <= vid_addr;
    for (int i = 1; i < W - 1; i++) dly[i] <= dly[i-1];
  end
  assign vid_data = dly[W-2][16:1];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int doneCount = 0;

  // Reference model state.
  bit          mActive;
  int          mElapsed;
  logic [24:0] mBase;
  logic [24:0] mAddr;
  bit          mBank;
  bit          mBusy;
  bit          mDone;
  bit          mOverrun;
  logic [15:0] mRd;
  bit          mRdKnown;
  logic [15:0] bankMem [2][LW];
  bit          bankValid [2][LW];

  typedef struct {
    int          cyc;
    logic [24:0] addr;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tab[$];

  function automatic logic [15:0] wordAt(input logic [24:0] a);
    return a[16:1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s cycle %0d got %h want %h", name, cycle, act, exp);
    end
  endtask

  // Drive one clock of inputs, advance the model across the edge, compare.
  task automatic applyStimulus(input bit rstn, input bit ls, input logic [24:0] base,
                               input logic [1:0] ra);
    int k;
    init_n     = rstn;
    line_start = ls;
    line_base  = base;
    rd_addr    = ra;
    @(posedge clk);
    cycle++;
    if (!rstn) begin
      mActive  = 0;
      mAddr    = 25'd0;
      mBusy    = 0;
      mDone    = 0;
      mOverrun = 0;
      mBank    = 0;
      mRd      = 16'd0;
      mRdKnown = 1;
    end else begin
      mRdKnown = bankValid[!mBank][ra];
      mRd      = bankMem[!mBank][ra];
      mDone    = 0;
      if (mActive) begin
        mElapsed++;
        if (mElapsed % W == 0) begin
          k = mElapsed / W - 1;
          bankMem[mBank][k]   = wordAt(25'(mBase + 25'(2 * k)));
          bankValid[mBank][k] = 1;
          if (k == LW - 1) begin
            mActive = 0;
            mDone   = 1;
          end
        end
      end
      if (ls) begin
        if (mActive) mOverrun = 1;
        mBank    = !mBank;
        mActive  = 1;
        mBase    = base;
        mElapsed = 0;
      end
      if (mActive) mAddr = 25'(mBase + 25'(2 * (mElapsed / W)));
      mBusy = mActive;
    end
    #1;
    checkOutput("vid_addr", 32'(vid_addr), 32'(mAddr));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("overrun", 32'(overrun), 32'(mOverrun));
    if (mRdKnown) checkOutput("rd_data", 32'(rd_data), 32'(mRd));
    if (done) doneCount++;
  endtask

  task automatic idleTick();
    applyStimulus(1'b1, 1'b0, 25'd0, 2'($urandom_range(0, 3)));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      idleTick();
      n++;
    end
    checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Run one full line from line_start and check the table entries on the way.
  task automatic runLine(input logic [24:0] base);
    for (int e = 0; e <= LW * W + 1; e++) begin
      applyStimulus(1'b1, e == 0, base, 2'($urandom_range(0, 3)));
      for (int i = 0; i < tab.size(); i++) begin
        if (tab[i].cyc == e) begin
          checkOutput("tab_addr", 32'(vid_addr), 32'(tab[i].addr));
          checkOutput("tab_busy", 32'(busy), 32'(tab[i].busy));
          checkOutput("tab_done", 32'(done), 32'(tab[i].done));
        end
      end
    end
  endtask

  // Start a fresh line and read back the previous line through rd_data.
  task automatic readBack(input logic [24:0] nextBase, input logic [15:0] first, input logic [15:0] step);
    applyStimulus(1'b1, 1'b1, nextBase, 2'd0);
    for (int ra = 0; ra < LW; ra++) begin
      applyStimulus(1'b1, 1'b0, 25'd0, 2'(ra));
      checkOutput("readback", 32'(rd_data), 32'(16'(first + 16'(ra) * step)));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int firstDone;
    init_n     = 1'b0;
    line_start = 1'b0;
    line_base  = 25'd0;
    rd_addr    = 2'd0;
    mActive    = 0;
    mElapsed   = 0;
    mBase      = 25'd0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LW; i++) bankValid[b][i] = 0;

    // Reset long enough to flush the controller delay line.
    for (int i = 0; i < W + 5; i++) applyStimulus(1'b0, 1'b0, 25'd0, 2'($urandom_range(0, 3)));
    checkOutput("reset_rd", 32'(rd_data), 32'd0);
    checkOutput("reset_addr", 32'(vid_addr), 32'd0);

    // Basic line: each address held 20 clocks, done 80 clocks after start.
    tab.delete();
    tab.push_back(vec_t'{0,  25'h0001000, 1'b1, 1'b0});
    tab.push_back(vec_t'{19, 25'h0001000, 1'b1, 1'b0});
    tab.push_back(vec_t'{20, 25'h0001002, 1'b1, 1'b0});
    tab.push_back(vec_t'{39, 25'h0001002, 1'b1, 1'b0});
    tab.push_back(vec_t'{40, 25'h0001004, 1'b1, 1'b0});
    tab.push_back(vec_t'{60, 25'h0001006, 1'b1, 1'b0});
    tab.push_back(vec_t'{79, 25'h0001006, 1'b1, 1'b0});
    tab.push_back(vec_t'{80, 25'h0001006, 1'b0, 1'b1});
    tab.push_back(vec_t'{81, 25'h0001006, 1'b0, 1'b0});
    runLine(25'h0001000);

    // Bank swap: the finished line is readable right after the next start.
    applyStimulus(1'b1, 1'b1, 25'h0002000, 2'd0);
    applyStimulus(1'b1, 1'b0, 25'd0, 2'd2);
    checkOutput("swap_rd1", 32'(rd_data), 32'h0802);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 25'h0003000, 2'd0);
    applyStimulus(1'b1, 1'b0, 25'd0, 2'd2);
    checkOutput("swap_rd2", 32'(rd_data), 32'h1002);
    waitIdle();

    // Overrun: second line_start 30 clocks after the first.
    d0 = doneCount;
    applyStimulus(1'b1, 1'b1, 25'h0004000, 2'd0);
    for (int e = 1; e < 30; e++) idleTick();
    applyStimulus(1'b1, 1'b1, 25'h0005000, 2'd0);
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    checkOutput("ovr_addr", 32'(vid_addr), 32'h0005000);
    checkOutput("ovr_nodone", 32'(doneCount - d0), 32'd0);
    firstDone = -1;
    for (int e = 1; e <= LW * W; e++) begin
      idleTick();
      if (done && firstDone < 0) firstDone = e;
    end
    checkOutput("ovr_done_at", 32'(firstDone), 32'(LW * W));
    checkOutput("ovr_done_cnt", 32'(doneCount - d0), 32'd1);

    // Reset during word 2: everything clears and no done follows.
    applyStimulus(1'b1, 1'b1, 25'h0008000, 2'd0);
    for (int e = 1; e < 45; e++) idleTick();
    applyStimulus(1'b0, 1'b0, 25'd0, 2'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr", 32'(vid_addr), 32'd0);
    checkOutput("rst_ovr", 32'(overrun), 32'd0);
    d0 = doneCount;
    for (int e = 0; e < 100; e++) idleTick();
    checkOutput("rst_nodone", 32'(doneCount - d0), 32'd0);
    applyStimulus(1'b1, 1'b1, 25'h0009000, 2'd0);
    waitIdle();
    checkOutput("rst_refetch", 32'(doneCount - d0), 32'd1);
    readBack(25'h000C000, 16'h4800, 16'd1);
    waitIdle();

    // line_start coinciding with the final store: done pulses, restart wins.
    applyStimulus(1'b1, 1'b1, 25'h000A000, 2'd0);
    for (int e = 1; e < LW * W; e++) idleTick();
    applyStimulus(1'b1, 1'b1, 25'h000B000, 2'd0);
    checkOutput("coin_done", 32'(done), 32'd1);
    checkOutput("coin_busy", 32'(busy), 32'd1);
    checkOutput("coin_ovr", 32'(overrun), 32'd0);
    checkOutput("coin_addr", 32'(vid_addr), 32'h000B000);
    waitIdle();

    // Address wrap at the top of the 25-bit space.
    tab.delete();
    tab.push_back(vec_t'{0,  25'h1FFFFFC, 1'b1, 1'b0});
    tab.push_back(vec_t'{20, 25'h1FFFFFE, 1'b1, 1'b0});
    tab.push_back(vec_t'{40, 25'h0000000, 1'b1, 1'b0});
    tab.push_back(vec_t'{60, 25'h0000002, 1'b1, 1'b0});
    tab.push_back(vec_t'{80, 25'h0000002, 1'b0, 1'b1});
    runLine(25'h1FFFFFC);

    // Same-address restart: port does not move, held word is stored.
    applyStimulus(1'b1, 1'b1, 25'h0000002, 2'd0);
    checkOutput("same_addr", 32'(vid_addr), 32'h0000002);
    waitIdle();
    readBack(25'h000D000, 16'h0001, 16'd1);
    waitIdle();

    // Randomised lines: mixed gaps (overrun, coincident, idle), odd and
    // wrapping bases, repeated addresses, rd_addr and occasional resets.
    for (int n = 0; n < 40; n++) begin
      int gap;
      int sel;
      logic [24:0] b;
      sel = $urandom_range(0, 3);
      case (sel)
        0: b = 25'($urandom);
        1: b = mAddr;
        2: b = 25'h1FFFFF8 | 25'($urandom_range(0, 1));
        default: b = 25'($urandom) & 25'h00FFFFE;
      endcase
      sel = $urandom_range(0, 3);
      case (sel)
        0: gap = $urandom_range(1, LW * W - 1);
        1: gap = LW * W;
        default: gap = $urandom_range(LW * W + 1, LW * W + 30);
      endcase
      applyStimulus($urandom_range(0, 49) != 0, 1'b1, b, 2'($urandom_range(0, 3)));
      for (int e = 1; e < gap; e++)
        applyStimulus($urandom_range(0, 299) != 0, 1'b0, 25'd0, 2'($urandom_range(0, 3)));
    end
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
